div_seq_ctrl: RTL and testbench
===============================

Name: div_seq_ctrl

Overview:
Multi-cycle sequencer for signed 32-bit division in the CPU's HI/LO path. It computes one quotient bit per clock using the non-restoring algorithm, so the datapath does not need a 32-stage combinational divider. It takes a start/busy/done handshake from the control unit and returns {remainder, quotient} in the same 64-bit packing the HI/LO registers already use. Results are held stable until the next accepted start.

Parameters:
WIDTH, 32, operand width in bits; the result is 2*WIDTH bits.

Ports:
clock  in  1  system clock; all state changes on the rising edge
clear  in  1  synchronous, active-high reset
start  in  1  request a division; sampled only in IDLE
a  in  WIDTH  signed dividend; captured on the cycle start is accepted
b  in  WIDTH  signed divisor; captured on the cycle start is accepted
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse; result is valid from this cycle onward
div_by_zero  out  1  set with done when b==0; held until the next accepted start
result  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}

Behaviour:
- Reset: clear=1 at an edge forces state=IDLE and busy=0, done=0, div_by_zero=0, result=0, and zeroes all internal registers. This applies in any state; an in-flight division is abandoned with no done pulse.
- States and transitions:
  - IDLE:
    - start=1 captures a and b and goes to PREP.
    - start=1 with b==0 goes to ZDIV instead.
    - start=0 stays in IDLE.
  - PREP (1 cycle):
    - latch sign_q = a[MSB]^b[MSB] and sign_r = a[MSB].
    - latch |a| into Q and |b| into M; set A=0 and count=WIDTH-1.
    - go to ITER.
  - ITER (WIDTH cycles, one bit per cycle):
    - shift {A,Q} left by 1.
    - if the old A[MSB]==0 then A=A-M, else A=A+M.
    - Q[0] = ~A_new[MSB].
    - count decrements; when count==0, go to FIX.
  - FIX (1 cycle):
    - if A[MSB]==1, A=A+M.
    - negate Q if sign_q; negate A if sign_r.
    - write result={A,Q} and go to DONE.
  - ZDIV (1 cycle): write result={a_captured, {WIDTH{1'b1}}}, set div_by_zero=1, go to DONE.
  - DONE (1 cycle): done=1, busy=0, then go to IDLE.
- Latency:
  - Normal case: start accepted at edge 0, PREP at edge 1, ITER at edges 2..WIDTH+1, FIX at edge WIDTH+2. done is high for the cycle after edge WIDTH+2, which is 35 cycles for WIDTH=32.
  - b==0 case: done arrives 2 cycles after start.
- busy is high in PREP, ITER, FIX and ZDIV.
- start while not IDLE (including DONE) is ignored; no queuing.
- start in IDLE on the cycle right after done is accepted, giving back-to-back operations.
- result and div_by_zero change only in FIX or ZDIV, or on clear. The next accepted start clears div_by_zero at the PREP or ZDIV edge.
- Sign rules:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend, or is 0.
  - |quotient|*|b| + |remainder| = |a|.
- Width rules: A, Q and M are WIDTH bits; all arithmetic is modulo 2^WIDTH.
- Overflow: a=0x80000000, b=0xFFFFFFFF gives quotient=0x80000000 (wrapped), remainder=0, div_by_zero=0. No trap is raised.
- |a| of 0x80000000 is 0x80000000, which the algorithm treats as unsigned 2^31 magnitude.

Test Plan:
- a=100, b=7, start pulse -> done exactly 35 cycles later; result={32'd2, 32'd14}; div_by_zero=0; busy high for 34 cycles.
- a=-100, b=7 -> quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2). a=100, b=-7 -> quotient=-14, remainder=2. a=-100, b=-7 -> quotient=14, remainder=-2.
- a=12345, b=0 -> done 2 cycles after start; div_by_zero=1; result={32'd12345, 32'hFFFFFFFF}. The next start with a=9, b=3 clears div_by_zero and returns {0, 3}.
- a=0x80000000, b=0xFFFFFFFF -> result={0, 0x80000000}. Also check a=0x80000000, b=1 and a=0, b=5 -> {0, 0}.
- Assert clear at cycle 10 of a division -> next cycle busy=0, result=0, no done pulse. Also check start held high during ITER is ignored and the original result is unchanged.
- Back-to-back: start asserted the cycle after done -> second result correct; 500 random signed pairs (b≠0) checked against the reference model of / and % with truncation toward zero.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - multi-cycle signed non-restoring divider sequencer for the HI/LO path
module div_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_ZDIV = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;
  // Partial remainder carries one extra sign bit so divisors up to 2^(WIDTH-1)
  // in magnitude never overflow during the shift/add-subtract step.
  logic [WIDTH:0]   acc;
  logic [CW-1:0]    count;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   acc_step;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  // Status outputs are pure decodes of the sequencer state.
  always_comb begin
    busy = (state == S_PREP) || (state == S_ITER) || (state == S_FIX) || (state == S_ZDIV);
    done = (state == S_DONE);
  end

  // Datapath: magnitudes, one non-restoring step, and final correction/sign fix-up.
  always_comb begin
    m_ext    = {1'b0, m_reg};
    shifted  = {acc[WIDTH-1:0], q_reg[WIDTH-1]};
    acc_step = acc[WIDTH] ? (shifted + m_ext) : (shifted - m_ext);
    a_mag    = a_reg[WIDTH-1] ? (~a_reg + 1'b1) : a_reg;
    b_mag    = b_reg[WIDTH-1] ? (~b_reg + 1'b1) : b_reg;
    // A negative final partial remainder is restored; the true remainder is
    // below M, so the sum is exact modulo 2^WIDTH.
    rem_mag  = acc[WIDTH] ? (acc[WIDTH-1:0] + m_reg) : acc[WIDTH-1:0];
    quot_fix = sign_q ? (~q_reg + 1'b1) : q_reg;
    rem_fix  = sign_r ? (~rem_mag + 1'b1) : rem_mag;
  end

  // Sequencer state, operand capture and iteration registers.
  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= S_IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      q_reg       <= '0;
      m_reg       <= '0;
      acc         <= '0;
      count       <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      div_by_zero <= 1'b0;
      result      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            state <= (b == '0) ? S_ZDIV : S_PREP;
          end
        end
        S_PREP: begin
          sign_q      <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
          sign_r      <= a_reg[WIDTH-1];
          q_reg       <= a_mag;
          m_reg       <= b_mag;
          acc         <= '0;
          count       <= CW'(WIDTH - 1);
          div_by_zero <= 1'b0;
          state       <= S_ITER;
        end
        S_ITER: begin
          acc   <= acc_step;
          q_reg <= {q_reg[WIDTH-2:0], ~acc_step[WIDTH]};
          if (count == '0) begin
            state <= S_FIX;
          end else begin
            count <= count - 1'b1;
          end
        end
        S_FIX: begin
          result <= {rem_fix, quot_fix};
          state  <= S_DONE;
        end
        S_ZDIV: begin
          result      <= {a_reg, {WIDTH{1'b1}}};
          div_by_zero <= 1'b1;
          state       <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb/tb_div_seq_ctrl.sv - scoreboard bench for div_seq_ctrl
module tb_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        dbz;
  logic [63:0] result;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [63:0] res;
    logic        dz;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  div_seq_ctrl #(.WIDTH(32)) dut (
    .clock      (clk),
    .clear      (clear),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .div_by_zero(dbz),
    .result     (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: got no done expected done within bound", name);
  endtask

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
    longint sx;
    longint sy;
    longint q;
    longint r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    q  = sx / sy;
    r  = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done=1 expected done=0");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_result"}, result, e.res);
        check({e.name, "_dbz"}, {63'd0, dbz}, {63'd0, e.dz});
      end
    end
  end

  task automatic wait_done(input string name, output int lat, output int busy_cnt);
    bit got;
    got = 0;
    lat = 0;
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
      if (done) begin
        got = 1;
        break;
      end
    end
    if (!got) fail_now({name, "_timeout"});
  endtask

  task automatic do_op(input string name, input logic [31:0] ai, input logic [31:0] bi,
                       input logic [63:0] exp_res, input logic exp_dz, input int exp_lat);
    int lat;
    int bc;
    @(negedge clk);
    a = ai;
    b = bi;
    start = 1'b1;
    sb_q.push_back('{exp_res, exp_dz, name});
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(name, lat, bc);
    if (done && exp_lat != 0) begin
      check({name, "_latency"}, 64'(lat), 64'(exp_lat));
      check({name, "_busy_cycles"}, 64'(bc), 64'(exp_lat - 1));
    end
  endtask

  initial begin
    int lat;
    int bc;
    logic [31:0] ra;
    logic [31:0] rb;

    clear = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_dbz", {63'd0, dbz}, 64'd0);
    check("reset_result", result, 64'd0);
    clear = 1'b0;

    do_op("p_p", 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 35);
    do_op("n_p", 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 1'b0, 35);
    do_op("p_n", 32'd100, 32'hFFFFFFF9, {32'd2, 32'hFFFFFFF2}, 1'b0, 35);
    do_op("n_n", 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14}, 1'b0, 35);
    do_op("zdiv", 32'd12345, 32'd0, {32'd12345, 32'hFFFFFFFF}, 1'b1, 2);
    do_op("after_zdiv", 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, 35);
    do_op("ovf", 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 1'b0, 35);
    do_op("min_by_1", 32'h80000000, 32'd1, {32'd0, 32'h80000000}, 1'b0, 35);
    do_op("zero_num", 32'd0, 32'd5, {32'd0, 32'd0}, 1'b0, 35);
    do_op("small_num", 32'd7, 32'd100, {32'd7, 32'd0}, 1'b0, 35);
    do_op("max_by_min", 32'h7FFFFFFF, 32'h80000000, {32'h7FFFFFFF, 32'd0}, 1'b0, 35);

    repeat (3) @(negedge clk);
    check("hold_result", result, {32'h7FFFFFFF, 32'd0});

    // start kept high through PREP/ITER with new operands must be ignored
    @(negedge clk);
    a = 32'd1000;
    b = 32'hFFFFFFDF;
    start = 1'b1;
    sb_q.push_back('{{32'd10, 32'hFFFFFFE2}, 1'b0, "start_in_iter"});
    @(posedge clk);
    #1 a = 32'd5;
    b = 32'd0;
    repeat (6) @(negedge clk);
    start = 1'b0;
    wait_done("start_in_iter", lat, bc);

    // clear mid-division abandons it without a done pulse
    @(negedge clk);
    a = 32'd555;
    b = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    check("clear_busy", {63'd0, busy}, 64'd0);
    check("clear_done", {63'd0, done}, 64'd0);
    check("clear_result", result, 64'd0);
    check("clear_dbz", {63'd0, dbz}, 64'd0);
    repeat (40) @(negedge clk);

    // back-to-back random signed pairs
    for (int i = 0; i < 500; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (rb == 32'd0) rb = 32'd1;
      do_op("rand", ra, rb, model(ra, rb), 1'b0, 35);
    end

    repeat (2) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
